fetch_pair_gen: RTL and testbench

- Producer end of the IF2→ID1 instruction buffer interface.
- Holds the fetch PC and issues one 8-byte-aligned request per fetch to the ICache.
- Returns up to two instructions per response, driven as PC/IR pairs with a 2-bit valid code into the buffer.
- Honours buffer-full backpressure and branch-flush redirect, and drives the stall_ICache indication that the buffer consumes.

---
 rtl/if_pkg.sv | 8 +
 rtl/fetch_pair_gen.sv | 73 +++++++
 tb/tb_fetch_pair_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage types and constants for the IF2->ID1 pair generator.
package if_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam logic [1:0] VALID_NONE = 2'b00;
  localparam logic [1:0] VALID_ONE = 2'b10;
  localparam logic [1:0] VALID_TWO = 2'b11;
endpackage

// File: rtl/fetch_pair_gen.sv
// fetch_pair_gen: issues aligned ICache fetches and emits PC/IR pairs into the instruction buffer.
module fetch_pair_gen
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_buf_full,
  input  logic        i_flush_BR,
  input  logic [31:0] i_br_target,
  output logic        o_ic_req,
  output logic [31:0] o_ic_addr,
  input  logic        i_ic_ready,
  input  logic        i_ic_valid,
  input  logic [63:0] i_ic_data,
  output logic [31:0] o_PC1,
  output logic [31:0] o_IR1,
  output logic [31:0] o_PC2,
  output logic [31:0] o_IR2,
  output logic [1:0]  o_is_valid,
  output logic        o_stall_ICache
);
  fetch_state_e r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic r_drop, w_drop_nxt, w_resp, w_deliver;
  assign o_ic_addr = {r_pc[31:3], 3'b000};
  assign o_stall_ICache = (r_state == WAIT) & ~r_drop;
  always_comb begin
    o_ic_req = (r_state == REQ) & ~i_buf_full;
    w_resp = (r_state == WAIT) & i_ic_valid;
    w_deliver = w_resp & ~r_drop & ~i_flush_BR;
    w_state_nxt = i_flush_BR ? ((r_state == WAIT && !i_ic_valid) ? WAIT : REQ)
                : (r_state == IDLE) ? REQ
                : (r_state == REQ) ? ((o_ic_req && i_ic_ready) ? WAIT : REQ)
                : (i_ic_valid ? REQ : WAIT);
    // a flush that finds the request still in flight must swallow its eventual response
    w_drop_nxt = (i_flush_BR & (r_state == WAIT) & ~i_ic_valid) | (r_drop & ~w_resp);
    w_pc_nxt = i_flush_BR ? {i_br_target[31:2], 2'b00}
             : w_deliver ? r_pc + (r_pc[2] ? 32'd4 : 32'd8)
             : r_pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_drop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      r_drop <= w_drop_nxt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_is_valid <= VALID_NONE;
      o_PC1 <= '0;
      o_IR1 <= '0;
      o_PC2 <= '0;
      o_IR2 <= '0;
    end else begin
      o_is_valid <= w_deliver ? (r_pc[2] ? VALID_ONE : VALID_TWO) : VALID_NONE;
      if (w_deliver) begin
        o_PC1 <= r_pc;
        o_IR1 <= r_pc[2] ? i_ic_data[63:32] : i_ic_data[31:0];
        if (!r_pc[2]) begin
          o_PC2 <= r_pc + 32'd4;
          o_IR2 <= i_ic_data[63:32];
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_pair_gen.sv
// tb_fetch_pair_gen: table-driven directed vectors, hand sequences and random traffic vs a fetch model.
module tb_fetch_pair_gen;
  logic clk = 0, rst = 1;
  logic i_buf_full = 0, i_flush_BR = 0, i_ic_ready = 0, i_ic_valid = 0;
  logic [31:0] i_br_target = 0;
  logic [63:0] i_ic_data = 0;
  logic o_ic_req, o_stall_ICache;
  logic [31:0] o_ic_addr, o_PC1, o_IR1, o_PC2, o_IR2;
  logic [1:0] o_is_valid;
  int n_cmp = 0, n_bad = 0;

  fetch_pair_gen dut (
    .clk(clk), .rst(rst), .i_buf_full(i_buf_full), .i_flush_BR(i_flush_BR),
    .i_br_target(i_br_target), .o_ic_req(o_ic_req), .o_ic_addr(o_ic_addr),
    .i_ic_ready(i_ic_ready), .i_ic_valid(i_ic_valid), .i_ic_data(i_ic_data),
    .o_PC1(o_PC1), .o_IR1(o_IR1), .o_PC2(o_PC2), .o_IR2(o_IR2),
    .o_is_valid(o_is_valid), .o_stall_ICache(o_stall_ICache)
  );

  always #5 clk = ~clk;

  // model: fetch PC, whether a request is in flight, whether its answer is stale
  logic [31:0] m_pc, m_pc1, m_ir1, m_pc2, m_ir2;
  logic m_started, m_inflight, m_stale;
  logic [1:0] m_v;

  task automatic model_reset();
    m_pc = 32'h1C00_0000; m_started = 0; m_inflight = 0; m_stale = 0;
    m_v = 0; m_pc1 = 0; m_ir1 = 0; m_pc2 = 0; m_ir2 = 0;
  endtask

  function automatic logic exp_req();
    return m_started && !m_inflight && !i_buf_full;
  endfunction

  task automatic model_edge();
    logic issue;
    issue = exp_req() && i_ic_ready;
    m_v = 0;
    if (!m_started) begin
      m_started = 1;
      if (i_flush_BR) m_pc = i_br_target & ~32'd3;
    end else if (i_flush_BR) begin
      m_pc = i_br_target & ~32'd3;
      if (m_inflight && !i_ic_valid) m_stale = 1;
      else begin m_inflight = 0; m_stale = 0; end
    end else if (m_inflight && i_ic_valid) begin
      if (!m_stale) begin
        m_pc1 = m_pc;
        if (m_pc % 8 == 0) begin
          m_ir1 = i_ic_data[31:0]; m_pc2 = m_pc + 4; m_ir2 = i_ic_data[63:32];
          m_v = 2'b11; m_pc = m_pc + 8;
        end else begin
          m_ir1 = i_ic_data[63:32]; m_v = 2'b10; m_pc = m_pc + 4;
        end
      end
      m_inflight = 0; m_stale = 0;
    end else if (issue) m_inflight = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // explicit expectations for the current cycle; mask bits: req,addr,vld,slot1,slot2,stall
  logic [5:0] x_mask = 0;
  logic x_req, x_stall;
  logic [1:0] x_vld;
  logic [31:0] x_addr, x_pc1, x_ir1, x_pc2, x_ir2;

  task automatic cyc();
    @(negedge clk);
    chk("model_req", {31'd0, o_ic_req}, {31'd0, exp_req()});
    chk("model_addr", o_ic_addr, {m_pc[31:3], 3'b000});
    chk("model_stall", {31'd0, o_stall_ICache}, {31'd0, m_inflight && !m_stale});
    chk("model_vld", {30'd0, o_is_valid}, {30'd0, m_v});
    chk("model_pc1", o_PC1, m_pc1);
    chk("model_ir1", o_IR1, m_ir1);
    chk("model_pc2", o_PC2, m_pc2);
    chk("model_ir2", o_IR2, m_ir2);
    if (x_mask[0]) chk("dir_req", {31'd0, o_ic_req}, {31'd0, x_req});
    if (x_mask[1]) chk("dir_addr", o_ic_addr, x_addr);
    if (x_mask[2]) chk("dir_vld", {30'd0, o_is_valid}, {30'd0, x_vld});
    if (x_mask[3]) begin chk("dir_pc1", o_PC1, x_pc1); chk("dir_ir1", o_IR1, x_ir1); end
    if (x_mask[4]) begin chk("dir_pc2", o_PC2, x_pc2); chk("dir_ir2", o_IR2, x_ir2); end
    if (x_mask[5]) chk("dir_stall", {31'd0, o_stall_ICache}, {31'd0, x_stall});
    @(posedge clk);
    model_edge();
    #1;
    x_mask = 0;
  endtask

  task automatic drive(input logic fl, input logic [31:0] tg, input logic full,
                       input logic rdy, input logic vld, input logic [63:0] d);
    i_flush_BR = fl; i_br_target = tg; i_buf_full = full;
    i_ic_ready = rdy; i_ic_valid = vld; i_ic_data = d;
  endtask

  typedef struct {
    logic fl; logic [31:0] tg; logic full, rdy, vld; logic [63:0] d;
    logic [5:0] mask; logic req; logic [31:0] addr; logic [1:0] v;
    logic [31:0] pc1, ir1, pc2, ir2; logic stall;
  } vec_t;
  vec_t tbl[14];

  initial begin
    model_reset();
    //         fl tg            full rdy vld data                      mask     req addr          v      pc1           ir1           pc2           ir2           stall
    tbl[0]  = '{0, 0,            0, 1, 0, 64'h0,                   6'b100111, 0, 32'h1C000000, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    tbl[1]  = '{0, 0,            0, 1, 0, 64'h0,                   6'b100011, 1, 32'h1C000000, 2'b00, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0,            0, 1, 0, 64'h0,                   6'b100001, 0, 0,            2'b00, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0,            0, 1, 1, 64'h00000002_00000001,   6'b100001, 0, 0,            2'b00, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0,            0, 0, 0, 64'h0,                   6'b111111, 1, 32'h1C000008, 2'b11, 32'h1C000000, 32'h00000001, 32'h1C000004, 32'h00000002, 0};
    tbl[5]  = '{1, 32'h1C000106, 0, 1, 0, 64'h0,                   6'b000100, 0, 0,            2'b00, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0,            0, 1, 0, 64'h0,                   6'b000011, 1, 32'h1C000100, 2'b00, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0,            0, 0, 1, 64'hBBBBBBBB_AAAAAAAA,   6'b100000, 0, 0,            2'b00, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 0,            1, 1, 0, 64'h0,                   6'b111111, 0, 32'h1C000108, 2'b10, 32'h1C000104, 32'hBBBBBBBB, 32'h1C000004, 32'h00000002, 0};
    tbl[9]  = '{0, 0,            1, 1, 0, 64'h0,                   6'b000111, 0, 32'h1C000108, 2'b00, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0,            1, 1, 0, 64'h0,                   6'b000011, 0, 32'h1C000108, 2'b00, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0,            1, 1, 0, 64'h0,                   6'b000011, 0, 32'h1C000108, 2'b00, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 0,            1, 1, 0, 64'h0,                   6'b000011, 0, 32'h1C000108, 2'b00, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0,            0, 0, 0, 64'h0,                   6'b000011, 1, 32'h1C000108, 2'b00, 0, 0, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    foreach (tbl[k]) begin
      drive(tbl[k].fl, tbl[k].tg, tbl[k].full, tbl[k].rdy, tbl[k].vld, tbl[k].d);
      x_mask = tbl[k].mask; x_req = tbl[k].req; x_addr = tbl[k].addr; x_vld = tbl[k].v;
      x_pc1 = tbl[k].pc1; x_ir1 = tbl[k].ir1; x_pc2 = tbl[k].pc2; x_ir2 = tbl[k].ir2;
      x_stall = tbl[k].stall;
      cyc();
    end
    // flush while waiting: late response must vanish, stall drops immediately
    drive(0, 0, 0, 1, 0, 0); cyc();
    drive(1, 32'h1C000200, 0, 0, 0, 0); x_mask = 6'b100000; x_stall = 1; cyc();
    drive(0, 0, 0, 0, 0, 0); x_mask = 6'b100001; x_req = 0; x_stall = 0; cyc();
    cyc(); cyc();
    drive(0, 0, 0, 0, 1, 64'h12345678_9ABCDEF0); cyc();
    drive(0, 0, 0, 0, 0, 0); x_mask = 6'b100111; x_vld = 0; x_req = 1; x_addr = 32'h1C000200; x_stall = 0; cyc();
    // flush colliding with the response
    drive(0, 0, 0, 1, 0, 0); cyc();
    drive(1, 32'h1C000300, 0, 0, 1, 64'h11111111_22222222); cyc();
    drive(0, 0, 0, 0, 0, 0); x_mask = 6'b000111; x_vld = 0; x_req = 1; x_addr = 32'h1C000300; cyc();
    // async reset in the middle of a wait, then a stale response
    drive(0, 0, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #2 rst = 1; #1;
    chk("rst_req", {31'd0, o_ic_req}, 32'd0);
    chk("rst_vld", {30'd0, o_is_valid}, 32'd0);
    chk("rst_pc1", o_PC1, 32'd0);
    chk("rst_ir2", o_IR2, 32'd0);
    chk("rst_stall", {31'd0, o_stall_ICache}, 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    drive(0, 0, 0, 0, 1, 64'hDEADBEEF_DEADBEEF); x_mask = 6'b000011; x_req = 0; x_addr = 32'h1C000000; cyc();
    drive(0, 0, 0, 0, 1, 64'hDEADBEEF_DEADBEEF); x_mask = 6'b000111; x_req = 1; x_addr = 32'h1C000000; x_vld = 0; cyc();
    drive(0, 0, 0, 0, 0, 0); x_mask = 6'b001100; x_vld = 0; x_pc1 = 0; x_ir1 = 0; cyc();
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 5, $urandom, $urandom_range(0, 99) < 20,
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 35, {$urandom, $urandom});
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
